// File: rtl/sm83_intc_pkg.sv
// Shared constants for the SM83 interrupt controller: register addresses,
// source count and the peripheral source numbering.
package sm83_intc_pkg;

    localparam int NUM_SRC  = 5;
    localparam int NUM_IRQS = 8;

    localparam logic [15:0] ADR_IF = 16'hFF0F;
    localparam logic [15:0] ADR_IE = 16'hFFFF;

    typedef enum logic [2:0] {
        VBLANK = 3'd0,
        STAT   = 3'd1,
        TIMER  = 3'd2,
        SERIAL = 3'd3,
        JOYPAD = 3'd4
    } src_idx_e;

endpackage

// File: rtl/sm83_edge_det.sv
// Rising-edge detector: rise_o is high for the cycle where in_i goes 0->1.
// The history register loads rst_val_i in reset, so reset-time levels are not edges.
module sm83_edge_det #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] in_i,
    input  logic [W-1:0] rst_val_i,
    output logic [W-1:0] rise_o
);

    logic [W-1:0] prev_q;

    always_ff @(posedge clk) begin
        if (reset) prev_q <= rst_val_i;
        else       prev_q <= in_i;
    end

    assign rise_o = in_i & ~prev_q;

endmodule

// File: rtl/sm83_intc.sv
// SM83 interrupt controller: IF/IE registers, edge-triggered sources and acks.
// Reads return data one cycle after the rd cycle; irq/wake come straight from the registers.
module sm83_intc
    import sm83_intc_pkg::*;
#(
    parameter int NUM_SRC  = sm83_intc_pkg::NUM_SRC,
    parameter int NUM_IRQS = sm83_intc_pkg::NUM_IRQS
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [15:0]         adr,
    input  logic [7:0]          din,
    input  logic                rd,
    input  logic                wr,
    output logic [7:0]          dout,
    output logic                dout_oe,
    input  logic [NUM_SRC-1:0]  src,
    output logic [NUM_IRQS-1:0] irq,
    input  logic [NUM_IRQS-1:0] iack,
    output logic                wake
);

    logic [NUM_SRC-1:0]  if_q, if_d;
    logic [7:0]          ie_q, ie_d;
    logic [7:0]          dout_q, dout_d;
    logic                oe_q, oe_d;
    logic [7:0]          if_rd;

    logic [NUM_SRC-1:0]  src_rise;
    logic [0:0]          wr_rise;
    logic [NUM_IRQS-1:0] ack_rise;

    sm83_edge_det #(.W(NUM_SRC)) u_src_edge (
        .clk      (clk),
        .reset    (reset),
        .in_i     (src),
        .rst_val_i(src),
        .rise_o   (src_rise)
    );

    // Strobes held across reset release must not look like fresh edges.
    sm83_edge_det #(.W(1)) u_wr_edge (
        .clk      (clk),
        .reset    (reset),
        .in_i     (wr),
        .rst_val_i(1'b1),
        .rise_o   (wr_rise)
    );

    sm83_edge_det #(.W(NUM_IRQS)) u_ack_edge (
        .clk      (clk),
        .reset    (reset),
        .in_i     (iack),
        .rst_val_i({NUM_IRQS{1'b1}}),
        .rise_o   (ack_rise)
    );

    always_comb begin
        if_rd = 8'hFF;
        if_rd[NUM_SRC-1:0] = if_q;

        if_d   = if_q;
        ie_d   = ie_q;
        dout_d = dout_q;
        oe_d   = 1'b0;

        if (wr_rise[0] && adr == ADR_IF) if_d = din[NUM_SRC-1:0];
        else                             if_d = if_q & ~ack_rise[NUM_SRC-1:0];
        if_d = if_d | src_rise;

        if (wr_rise[0] && adr == ADR_IE) ie_d = din;

        // A cycle with both strobes is a write; the bus is not driven.
        if (rd && !wr) begin
            if (adr == ADR_IF) begin
                dout_d = if_rd;
                oe_d   = 1'b1;
            end else if (adr == ADR_IE) begin
                dout_d = ie_q;
                oe_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            if_q   <= '0;
            ie_q   <= '0;
            dout_q <= '0;
            oe_q   <= 1'b0;
        end else begin
            if_q   <= if_d;
            ie_q   <= ie_d;
            dout_q <= dout_d;
            oe_q   <= oe_d;
        end
    end

    always_comb begin
        irq = '0;
        irq[NUM_SRC-1:0] = if_q & ie_q[NUM_SRC-1:0];
    end

    assign wake    = |irq;
    assign dout    = dout_q;
    assign dout_oe = oe_q;

endmodule

// File: tb/tb_sm83_intc.sv
// Directed vector bench for sm83_intc: one table row per clock, plus hand-written
// sequences around reset release.
module tb_sm83_intc;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] adr;
    logic [7:0]  din;
    logic        rd, wr;
    logic [7:0]  dout;
    logic        dout_oe;
    logic [4:0]  src;
    logic [7:0]  irq;
    logic [7:0]  iack;
    logic        wake;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sm83_intc dut (
        .clk    (clk),
        .reset  (reset),
        .adr    (adr),
        .din    (din),
        .rd     (rd),
        .wr     (wr),
        .dout   (dout),
        .dout_oe(dout_oe),
        .src    (src),
        .irq    (irq),
        .iack   (iack),
        .wake   (wake)
    );

    typedef struct {
        logic [15:0] adr;
        logic [7:0]  din;
        logic        rd;
        logic        wr;
        logic [4:0]  src;
        logic [7:0]  iack;
        logic [7:0]  exp_dout;
        logic        exp_oe;
        logic [7:0]  exp_irq;
        logic        exp_wake;
    } vec_t;

    localparam int NV = 35;
    vec_t tbl [NV];

    function automatic vec_t mkv(input logic [15:0] a, input logic [7:0] d, input logic r,
                                 input logic w, input logic [4:0] s, input logic [7:0] k,
                                 input logic [7:0] edo, input logic eoe,
                                 input logic [7:0] eirq, input logic ewk);
        vec_t v;
        v.adr = a; v.din = d; v.rd = r; v.wr = w; v.src = s; v.iack = k;
        v.exp_dout = edo; v.exp_oe = eoe; v.exp_irq = eirq; v.exp_wake = ewk;
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic [7:0] edo, input logic eoe,
                              input logic [7:0] eirq, input logic ewk);
        chk({tag, " dout"}, dout, edo);
        chk({tag, " dout_oe"}, {7'd0, dout_oe}, {7'd0, eoe});
        chk({tag, " irq"}, irq, eirq);
        chk({tag, " wake"}, {7'd0, wake}, {7'd0, ewk});
    endtask

    task automatic idle();
        adr = 16'h0000; din = 8'h00; rd = 1'b0; wr = 1'b0; iack = 8'h00;
    endtask

    initial begin
        // Reads after reset, IE write, src edge, src[0] high since reset
        tbl[0]  = mkv(16'hFF0F, 8'h00, 1, 0, 5'b00001, 8'h00, 8'hE0, 1, 8'h00, 0);
        tbl[1]  = mkv(16'hFFFF, 8'h00, 1, 0, 5'b00001, 8'h00, 8'h00, 1, 8'h00, 0);
        tbl[2]  = mkv(16'h0000, 8'h00, 0, 0, 5'b00001, 8'h00, 8'h00, 0, 8'h00, 0);
        tbl[3]  = mkv(16'hFFFF, 8'h05, 0, 1, 5'b00001, 8'h00, 8'h00, 0, 8'h00, 0);
        tbl[4]  = mkv(16'h0000, 8'h00, 0, 0, 5'b00101, 8'h00, 8'h00, 0, 8'h04, 1);
        tbl[5]  = mkv(16'hFF0F, 8'h00, 1, 0, 5'b00001, 8'h00, 8'hE4, 1, 8'h04, 1);
        tbl[6]  = mkv(16'hFFFF, 8'h00, 1, 0, 5'b00001, 8'h00, 8'h05, 1, 8'h04, 1);
        tbl[7]  = mkv(16'h1234, 8'h00, 1, 0, 5'b00001, 8'h00, 8'h05, 0, 8'h04, 1);
        // IE=0x04, held iack for 8 cycles with a src[2] edge in the middle
        tbl[8]  = mkv(16'hFFFF, 8'h04, 0, 1, 5'b00001, 8'h00, 8'h05, 0, 8'h04, 1);
        tbl[9]  = mkv(16'h0000, 8'h00, 0, 0, 5'b00001, 8'h00, 8'h05, 0, 8'h04, 1);
        tbl[10] = mkv(16'h0000, 8'h00, 0, 0, 5'b00001, 8'h04, 8'h05, 0, 8'h00, 0);
        tbl[11] = mkv(16'h0000, 8'h00, 0, 0, 5'b00101, 8'h04, 8'h05, 0, 8'h04, 1);
        tbl[12] = mkv(16'h0000, 8'h00, 0, 0, 5'b00101, 8'h04, 8'h05, 0, 8'h04, 1);
        tbl[13] = mkv(16'h0000, 8'h00, 0, 0, 5'b00101, 8'h04, 8'h05, 0, 8'h04, 1);
        tbl[14] = mkv(16'h0000, 8'h00, 0, 0, 5'b00001, 8'h04, 8'h05, 0, 8'h04, 1);
        tbl[15] = mkv(16'h0000, 8'h00, 0, 0, 5'b00001, 8'h04, 8'h05, 0, 8'h04, 1);
        tbl[16] = mkv(16'h0000, 8'h00, 0, 0, 5'b00001, 8'h04, 8'h05, 0, 8'h04, 1);
        tbl[17] = mkv(16'h0000, 8'h00, 0, 0, 5'b00001, 8'h04, 8'h05, 0, 8'h04, 1);
        tbl[18] = mkv(16'hFF0F, 8'h00, 1, 0, 5'b00001, 8'h00, 8'hE4, 1, 8'h04, 1);
        // IE=0xFF, wr held 4 cycles to IF; an ack in between exposes any re-commit
        tbl[19] = mkv(16'hFFFF, 8'hFF, 0, 1, 5'b00001, 8'h00, 8'hE4, 0, 8'h04, 1);
        tbl[20] = mkv(16'h0000, 8'h00, 0, 0, 5'b00001, 8'h00, 8'hE4, 0, 8'h04, 1);
        tbl[21] = mkv(16'hFF0F, 8'h1F, 0, 1, 5'b00001, 8'h00, 8'hE4, 0, 8'h1F, 1);
        tbl[22] = mkv(16'hFF0F, 8'h1F, 0, 1, 5'b00001, 8'h02, 8'hE4, 0, 8'h1D, 1);
        tbl[23] = mkv(16'hFF0F, 8'h1F, 0, 1, 5'b00001, 8'h02, 8'hE4, 0, 8'h1D, 1);
        tbl[24] = mkv(16'hFF0F, 8'h1F, 0, 1, 5'b00011, 8'h00, 8'hE4, 0, 8'h1F, 1);
        tbl[25] = mkv(16'h0000, 8'h00, 0, 0, 5'b00001, 8'h00, 8'hE4, 0, 8'h1F, 1);
        // IF write 0x00 loses to a same-cycle src[3] edge
        tbl[26] = mkv(16'hFF0F, 8'h00, 0, 1, 5'b01001, 8'h00, 8'hE4, 0, 8'h08, 1);
        tbl[27] = mkv(16'hFF0F, 8'h00, 1, 0, 5'b00001, 8'h00, 8'hE8, 1, 8'h08, 1);
        // rd and wr together act as a write with no bus drive
        tbl[28] = mkv(16'hFFFF, 8'h10, 1, 1, 5'b00001, 8'h00, 8'hE8, 0, 8'h00, 0);
        tbl[29] = mkv(16'hFFFF, 8'h00, 1, 0, 5'b00001, 8'h00, 8'h10, 1, 8'h00, 0);
        // Multi-bit ack clears every edged bit
        tbl[30] = mkv(16'hFF0F, 8'h1F, 0, 1, 5'b00001, 8'h00, 8'h10, 0, 8'h10, 1);
        tbl[31] = mkv(16'h0000, 8'h00, 0, 0, 5'b00001, 8'h00, 8'h10, 0, 8'h10, 1);
        tbl[32] = mkv(16'hFFFF, 8'hFF, 0, 1, 5'b00001, 8'h00, 8'h10, 0, 8'h1F, 1);
        tbl[33] = mkv(16'h0000, 8'h00, 0, 0, 5'b00001, 8'h05, 8'h10, 0, 8'h1A, 1);
        tbl[34] = mkv(16'hFF0F, 8'h00, 1, 0, 5'b00001, 8'h00, 8'hFA, 1, 8'h1A, 1);

        reset = 1'b1;
        src = 5'b00001;
        idle();
        step(); step(); step();
        check_outs("reset", 8'h00, 1'b0, 8'h00, 1'b0);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            adr = tbl[i].adr; din = tbl[i].din; rd = tbl[i].rd; wr = tbl[i].wr;
            src = tbl[i].src; iack = tbl[i].iack;
            if ($countones(tbl[i].iack) > 1)
                $display("note: protocol violation, multi-bit iack 0x%02h at vector %0d",
                         tbl[i].iack, i);
            step();
            check_outs($sformatf("v%0d", i), tbl[i].exp_dout, tbl[i].exp_oe,
                       tbl[i].exp_irq, tbl[i].exp_wake);
        end

        // wr to IE held across reset release must not commit
        idle();
        reset = 1'b1;
        adr = 16'hFFFF; din = 8'hFF; wr = 1'b1;
        step(); step();
        check_outs("rst2", 8'h00, 1'b0, 8'h00, 1'b0);
        reset = 1'b0;
        step(); step(); step();
        wr = 1'b0; adr = 16'h0000;
        src = 5'b00101;
        step();
        check_outs("rst2 src2 masked", 8'h00, 1'b0, 8'h00, 1'b0);
        src = 5'b00001; rd = 1'b1; adr = 16'hFF0F;
        step();
        check_outs("rst2 rd IF", 8'hE4, 1'b1, 8'h00, 1'b0);
        adr = 16'hFFFF;
        step();
        check_outs("rst2 rd IE", 8'h00, 1'b1, 8'h00, 1'b0);
        idle();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
